// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID->EX pipeline register with a load-use interlock, branch flush and a
// memory-busy freeze. Decoded fields and operands captured from decode are
// presented to EX-stage forwarding and the ALU one cycle later.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_RUN    | normal flow; a load-use hazard inserts the first bubble
// ST_LU_STALL | extra load-use bubbles; cnt_q counts the ones still owed
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   id_*_i                  decode-stage instruction fields and operands
//   flush_i                 taken branch in EX: kill the decode instruction
//   mem_busy_i              data memory not ready: freeze everything
//   stall_if_id_o           hold PC and IF/ID (combinational)
//   ex_*_o                  registered EX-stage fields; ex_valid_o=0 is a bubble
//   stall_cnt_o             saturating stall-cycle counter (HAZ_PERF_EN only)
//
// Optional feature macro: HAZ_PERF_EN adds the stall_cnt_o port and counter.
// ---------------------------------------------------------------------------
module id_ex_stage #(
    parameter int REG_W           = 4,
    parameter int DATA_W          = 32,
    parameter int LOAD_USE_CYCLES = 1,
    parameter bit R0_ZERO         = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid_i,
    input  logic [REG_W-1:0]  id_rs1_i,
    input  logic [REG_W-1:0]  id_rs2_i,
    input  logic              id_rs1_used_i,
    input  logic              id_rs2_used_i,
    input  logic [REG_W-1:0]  id_rd_i,
    input  logic [DATA_W-1:0] id_rs1_data_i,
    input  logic [DATA_W-1:0] id_rs2_data_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic [3:0]        id_alu_op_i,
    input  logic              id_reg_wr_i,
    input  logic              id_mem_rd_i,
    input  logic              id_mem_wr_i,
    input  logic              flush_i,
    input  logic              mem_busy_i,
    output logic              stall_if_id_o,
    output logic              ex_valid_o,
    output logic [REG_W-1:0]  ex_rs1_o,
    output logic [REG_W-1:0]  ex_rs2_o,
    output logic [REG_W-1:0]  ex_rd_o,
    output logic [DATA_W-1:0] ex_rs1_data_o,
    output logic [DATA_W-1:0] ex_rs2_data_o,
    output logic [DATA_W-1:0] ex_imm_o,
    output logic [3:0]        ex_alu_op_o,
    output logic              ex_reg_wr_o,
    output logic              ex_mem_rd_o,
    output logic              ex_mem_wr_o
`ifdef HAZ_PERF_EN
    ,
    output logic [31:0]       stall_cnt_o
`endif
);

    localparam int CNT_W = 3;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_LU_STALL = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               hazard, rd_is_zero;
    logic               capture, bubble, stall;

    logic               ex_valid_q, ex_reg_wr_q, ex_mem_rd_q, ex_mem_wr_q;
    logic [REG_W-1:0]   ex_rs1_q, ex_rs2_q, ex_rd_q;
    logic [DATA_W-1:0]  ex_rs1_data_q, ex_rs2_data_q, ex_imm_q;
    logic [3:0]         ex_alu_op_q;

    // A load in EX whose destination a decode source reads; writes to a
    // hardwired-zero r0 can never be a real dependency.
    assign rd_is_zero = (ex_rd_q == '0);
    assign hazard = id_valid_i & ex_valid_q & ex_mem_rd_q & ~(R0_ZERO & rd_is_zero)
                  & ((id_rs1_used_i & (id_rs1_i == ex_rd_q))
                   | (id_rs2_used_i & (id_rs2_i == ex_rd_q)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        bubble  = 1'b0;
        stall   = 1'b0;
        if (mem_busy_i) begin
            // Freeze: nothing moves; a pending flush is replayed by upstream.
            stall = 1'b1;
        end else if (flush_i) begin
            bubble  = 1'b1;
            state_d = ST_RUN;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (hazard) begin
                        bubble = 1'b1;
                        stall  = 1'b1;
                        if (LOAD_USE_CYCLES > 1) begin
                            cnt_d   = CNT_W'(LOAD_USE_CYCLES - 1);
                            state_d = ST_LU_STALL;
                        end
                    end else begin
                        capture = 1'b1;
                    end
                end
                ST_LU_STALL: begin
                    bubble = 1'b1;
                    stall  = 1'b1;
                    cnt_d  = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    // Bubbles only clear the valid and control bits; indices and operands
    // keep stale values since nothing downstream qualifies them without valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q    <= 1'b0;
            ex_reg_wr_q   <= 1'b0;
            ex_mem_rd_q   <= 1'b0;
            ex_mem_wr_q   <= 1'b0;
            ex_rs1_q      <= '0;
            ex_rs2_q      <= '0;
            ex_rd_q       <= '0;
            ex_rs1_data_q <= '0;
            ex_rs2_data_q <= '0;
            ex_imm_q      <= '0;
            ex_alu_op_q   <= '0;
        end else if (capture) begin
            ex_valid_q    <= id_valid_i;
            ex_reg_wr_q   <= id_reg_wr_i & id_valid_i;
            ex_mem_rd_q   <= id_mem_rd_i & id_valid_i;
            ex_mem_wr_q   <= id_mem_wr_i & id_valid_i;
            ex_rs1_q      <= id_rs1_i;
            ex_rs2_q      <= id_rs2_i;
            ex_rd_q       <= id_rd_i;
            ex_rs1_data_q <= id_rs1_data_i;
            ex_rs2_data_q <= id_rs2_data_i;
            ex_imm_q      <= id_imm_i;
            ex_alu_op_q   <= id_alu_op_i;
        end else if (bubble) begin
            ex_valid_q    <= 1'b0;
            ex_reg_wr_q   <= 1'b0;
            ex_mem_rd_q   <= 1'b0;
            ex_mem_wr_q   <= 1'b0;
        end
    end

    assign stall_if_id_o = stall;
    assign ex_valid_o    = ex_valid_q;
    assign ex_rs1_o      = ex_rs1_q;
    assign ex_rs2_o      = ex_rs2_q;
    assign ex_rd_o       = ex_rd_q;
    assign ex_rs1_data_o = ex_rs1_data_q;
    assign ex_rs2_data_o = ex_rs2_data_q;
    assign ex_imm_o      = ex_imm_q;
    assign ex_alu_op_o   = ex_alu_op_q;
    assign ex_reg_wr_o   = ex_reg_wr_q;
    assign ex_mem_rd_o   = ex_mem_rd_q;
    assign ex_mem_wr_o   = ex_mem_wr_q;

`ifdef HAZ_PERF_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    // No stall counter in this build.
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage. Three instances share one stimulus stream:
//   u[0] LOAD_USE_CYCLES=1 R0_ZERO=1, u[1] LOAD_USE_CYCLES=3 R0_ZERO=1,
//   u[2] LOAD_USE_CYCLES=1 R0_ZERO=0.
// Each has its own behavioural model: an EX slot plus a number of owed bubbles.
module tb_id_ex_stage;

    logic clk;
    logic rst_n;
    logic iv, u1, u2, rw, mr, mw, fl, mb;
    logic [3:0]  rs1, rs2, rd, op;
    logic [31:0] d1, d2, imm;

    logic [2:0]       stall_o, exv, exrw, exmr, exmw;
    logic [2:0][3:0]  exrs1, exrs2, exrd, exop;
    logic [2:0][31:0] exd1, exd2, eximm;
`ifdef HAZ_PERF_EN
    logic [2:0][31:0] scnt;
`endif

    for (genvar g = 0; g < 3; g++) begin : g_dut
        id_ex_stage #(
            .REG_W(4), .DATA_W(32),
            .LOAD_USE_CYCLES((g == 1) ? 3 : 1),
            .R0_ZERO((g == 2) ? 1'b0 : 1'b1)
        ) u (
            .clk(clk), .rst_n(rst_n),
            .id_valid_i(iv), .id_rs1_i(rs1), .id_rs2_i(rs2),
            .id_rs1_used_i(u1), .id_rs2_used_i(u2), .id_rd_i(rd),
            .id_rs1_data_i(d1), .id_rs2_data_i(d2), .id_imm_i(imm),
            .id_alu_op_i(op), .id_reg_wr_i(rw), .id_mem_rd_i(mr), .id_mem_wr_i(mw),
            .flush_i(fl), .mem_busy_i(mb),
            .stall_if_id_o(stall_o[g]), .ex_valid_o(exv[g]),
            .ex_rs1_o(exrs1[g]), .ex_rs2_o(exrs2[g]), .ex_rd_o(exrd[g]),
            .ex_rs1_data_o(exd1[g]), .ex_rs2_data_o(exd2[g]), .ex_imm_o(eximm[g]),
            .ex_alu_op_o(exop[g]), .ex_reg_wr_o(exrw[g]),
            .ex_mem_rd_o(exmr[g]), .ex_mem_wr_o(exmw[g])
`ifdef HAZ_PERF_EN
            , .stall_cnt_o(scnt[g])
`endif
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v, rw, mr, mw;
        logic [3:0]  rs1, rs2, rd, op;
        logic [31:0] d1, d2, imm;
        int          owed;
        longint      sc;
    } slot_t;

    slot_t m[3];
    int    n_chk  = 0;
    int    n_fail = 0;
    int    seen[3];

    function automatic int luc_of(int k);
        return (k == 1) ? 3 : 1;
    endfunction

    function automatic bit r0z_of(int k);
        return (k != 2);
    endfunction

    function automatic bit hz_m(int k);
        bit dep;
        dep = (u1 && rs1 == m[k].rd) || (u2 && rs2 == m[k].rd);
        return iv && m[k].v && m[k].mr && !(r0z_of(k) && m[k].rd == 4'd0) && dep;
    endfunction

    function automatic bit stall_m(int k);
        if (mb) return 1'b1;
        if (fl) return 1'b0;
        if (m[k].owed > 0) return 1'b1;
        return hz_m(k);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m[k].v = 0; m[k].rw = 0; m[k].mr = 0; m[k].mw = 0;
            m[k].rs1 = 0; m[k].rs2 = 0; m[k].rd = 0; m[k].op = 0;
            m[k].d1 = 0; m[k].d2 = 0; m[k].imm = 0;
            m[k].owed = 0; m[k].sc = 0;
        end
    endtask

    task automatic model_clock();
        for (int k = 0; k < 3; k++) begin
            bit h, s;
            h = hz_m(k);
            s = stall_m(k);
            if (s && m[k].sc != 64'hFFFF_FFFF) m[k].sc++;
            if (mb) begin
                // frozen
            end else if (fl || m[k].owed > 0 || h) begin
                if (fl)              m[k].owed = 0;
                else if (m[k].owed > 0) m[k].owed--;
                else                 m[k].owed = luc_of(k) - 1;
                m[k].v = 0; m[k].rw = 0; m[k].mr = 0; m[k].mw = 0;
            end else begin
                m[k].v = iv; m[k].rw = rw & iv; m[k].mr = mr & iv; m[k].mw = mw & iv;
                m[k].rs1 = rs1; m[k].rs2 = rs2; m[k].rd = rd; m[k].op = op;
                m[k].d1 = d1; m[k].d2 = d2; m[k].imm = imm;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("u%0d_valid", k), exv[k], m[k].v);
            chk($sformatf("u%0d_reg_wr", k), exrw[k], m[k].rw);
            chk($sformatf("u%0d_mem_rd", k), exmr[k], m[k].mr);
            chk($sformatf("u%0d_mem_wr", k), exmw[k], m[k].mw);
            if (m[k].v) begin
                chk($sformatf("u%0d_fields", k),
                    {exrs1[k], exrs2[k], exrd[k], exop[k], exd1[k][15:0], exd2[k][15:0]},
                    {m[k].rs1, m[k].rs2, m[k].rd, m[k].op, m[k].d1[15:0], m[k].d2[15:0]});
                chk($sformatf("u%0d_data", k), {exd1[k], eximm[k]}, {m[k].d1, m[k].imm});
                chk($sformatf("u%0d_rs2_data_hi", k), exd2[k][31:16], m[k].d2[31:16]);
            end
`ifdef HAZ_PERF_EN
            chk($sformatf("u%0d_stall_cnt", k), scnt[k], m[k].sc);
`endif
        end
    endtask

    task automatic check_reset_state();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("u%0d_rst_ctrl", k), {exv[k], exrw[k], exmr[k], exmw[k], stall_o[k]}, 64'd0);
            chk($sformatf("u%0d_rst_data", k),
                {exrs1[k], exrs2[k], exrd[k], exop[k], exd1[k] | exd2[k] | eximm[k]}, 64'd0);
`ifdef HAZ_PERF_EN
            chk($sformatf("u%0d_rst_stall_cnt", k), scnt[k], 64'd0);
`endif
        end
    endtask

    task automatic step(output bit any);
        @(negedge clk);
        any = 0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("u%0d_stall_if_id", k), stall_o[k], stall_m(k));
            if (stall_o[k]) seen[k]++;
            any = any | stall_m(k);
        end
        model_clock();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    // Present one instruction and hold it while any instance stalls.
    task automatic issue(input logic v, input logic [3:0] r_d, input logic [3:0] r1,
                         input logic us1, input logic [3:0] r2, input logic us2,
                         input logic ld, input logic wr, input logic st, input logic [3:0] o);
        bit any;
        int n;
        iv = v; rd = r_d; rs1 = r1; u1 = us1; rs2 = r2; u2 = us2;
        mr = ld; rw = wr; mw = st; op = o;
        d1 = $urandom; d2 = $urandom; imm = $urandom;
        n = 0;
        any = 1;
        while (any && n < 16) begin
            step(any);
            n++;
        end
        chk("hold_bound", any, 0);
    endtask

    task automatic clr_seen();
        for (int k = 0; k < 3; k++) seen[k] = 0;
    endtask

    initial begin
        bit any;
        rst_n = 0; iv = 0; u1 = 0; u2 = 0; rw = 0; mr = 0; mw = 0; fl = 0; mb = 0;
        rs1 = 0; rs2 = 0; rd = 0; op = 0; d1 = 0; d2 = 0; imm = 0;
        model_reset();
        clr_seen();
        repeat (2) @(posedge clk);
        #1;
        check_reset_state();
        rst_n = 1;

        // 1: independent ALU stream
        issue(1, 4'd1, 4'd7, 1, 4'd8, 1, 0, 1, 0, 4'd2);
        issue(1, 4'd2, 4'd1, 1, 4'd9, 1, 0, 1, 0, 4'd3);
        issue(1, 4'd3, 4'd2, 1, 4'd1, 1, 0, 1, 0, 4'd4);
        chk("t1_no_stall", seen[0] + seen[1] + seen[2], 0);

        // 2: LW r5 ; ADD rs1=r5
        clr_seen();
        issue(1, 4'd5, 4'd1, 1, 4'd0, 0, 1, 1, 0, 4'd0);
        issue(1, 4'd6, 4'd5, 1, 4'd3, 1, 0, 1, 0, 4'd1);
        chk("t2_stall_u0", seen[0], 1);
        chk("t2_stall_u1", seen[1], 3);
        chk("t2_stall_u2", seen[2], 1);
        chk("t2_add_in_ex", {exv[1], exrs1[1], exrd[1]}, {1'b1, 4'd5, 4'd6});

        // 3: LW r2 ; SUB rs2=r2
        clr_seen();
        issue(1, 4'd2, 4'd1, 1, 4'd0, 0, 1, 1, 0, 4'd0);
        issue(1, 4'd4, 4'd7, 1, 4'd2, 1, 0, 1, 0, 4'd6);
        chk("t3_stall_u0", seen[0], 1);
        chk("t3_stall_u1", seen[1], 3);
        chk("t3_stall_u2", seen[2], 1);
`ifdef HAZ_PERF_EN
        chk("t6_cnt_u0", scnt[0], 2);
        chk("t6_cnt_u1", scnt[1], 6);
`endif

        // 4: LW r0 ; ADD rs1=r0
        clr_seen();
        issue(1, 4'd0, 4'd1, 1, 4'd0, 0, 1, 1, 0, 4'd0);
        issue(1, 4'd7, 4'd0, 1, 4'd3, 1, 0, 1, 0, 4'd1);
        chk("t4_r0_u0", seen[0], 0);
        chk("t4_r0_u1", seen[1], 0);
        chk("t4_r0_u2", seen[2], 1);

        // 5: mem_busy with flush held for 4 cycles, then the flush lands
        issue(1, 4'd9, 4'd1, 1, 4'd2, 1, 0, 1, 0, 4'd5);
        clr_seen();
        mb = 1; fl = 1;
        for (int i = 0; i < 4; i++) begin
            iv = 1; rd = 4'(i + 10); rs1 = 4'(i); u1 = 1; mr = i[0]; rw = 1;
            d1 = $urandom; d2 = $urandom; imm = $urandom;
            step(any);
        end
        chk("t5_busy_stall_u0", seen[0], 4);
        chk("t5_busy_stall_u2", seen[2], 4);
        chk("t5_frozen", {exv, exrd[0], exrd[1]}, {3'b111, 4'd9, 4'd9});
        mb = 0;
        step(any);
        chk("t5_flush_bubble", {exv, exrw}, 6'd0);
        fl = 0;

        // 6: reset in the middle of a multi-cycle load-use stall
        issue(1, 4'd2, 4'd1, 1, 4'd0, 0, 1, 1, 0, 4'd0);
        iv = 1; rd = 4'd4; rs1 = 4'd7; u1 = 1; rs2 = 4'd2; u2 = 1; mr = 0; rw = 1; op = 4'd6;
        step(any);
        chk("t6_in_stall_u1", stall_o[1], 1);
        rst_n = 0;
        #2;
        model_reset();
        check_reset_state();
        rst_n = 1;
        clr_seen();
        step(any);
        chk("t6_no_residual", seen[1], 0);
        chk("t6_sub_in_ex", {exv[1], exrs2[1]}, {1'b1, 4'd2});

        // Randomised traffic with small register space to provoke hazards
        for (int i = 0; i < 400; i++) begin
            iv  = ($urandom_range(7) != 0);
            rs1 = 4'($urandom_range(3));
            rs2 = 4'($urandom_range(3));
            rd  = 4'($urandom_range(3));
            u1  = 1'($urandom_range(1));
            u2  = 1'($urandom_range(1));
            mr  = ($urandom_range(2) == 0);
            mw  = !mr && ($urandom_range(3) == 0);
            rw  = !mw;
            op  = 4'($urandom_range(15));
            d1  = $urandom; d2 = $urandom; imm = $urandom;
            mb  = ($urandom_range(7) == 0);
            fl  = ($urandom_range(9) == 0);
            step(any);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

endmodule
